// File: rtl/clk_div_sched_pkg.sv
// Shared types and defaults for the FIFO clock divider/scheduler.
// Top FSM encoding plus reset half-periods for the write/read clocks.
package clk_div_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int WR_HP_DEF = 3;
    localparam int RD_HP_DEF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        UPDATE = 2'd2,
        DRAIN  = 2'd3
    } state_e;

endpackage

// File: rtl/clk_div_sched_if.sv
// Control/config bundle between the config logic and the clock scheduler.
// The scheduler takes the slave side; the controller takes the master side.
interface clk_div_sched_if
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             run_en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_wr_hp;
    logic [CNT_W-1:0] cfg_rd_hp;
    logic             cfg_err;
    logic             w_clk;
    logic             r_clk;
    logic             w_clk_rise;
    logic             r_clk_rise;
    logic             busy;

    modport master (
        output run_en, cfg_valid, cfg_wr_hp, cfg_rd_hp,
        input  cfg_ready, cfg_err, w_clk, r_clk,
        input  w_clk_rise, r_clk_rise, busy
    );

    modport slave (
        input  run_en, cfg_valid, cfg_wr_hp, cfg_rd_hp,
        output cfg_ready, cfg_err, w_clk, r_clk,
        output w_clk_rise, r_clk_rise, busy
    );

endinterface

// File: rtl/clk_div_sched_chan.sv
// One divided-clock channel: counter, half-period reg, pending slot,
// run flag and registered clock/rise outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int HP_RST = WR_HP_DEF
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             go_i,
    input  logic             ld_i,
    input  logic [CNT_W-1:0] ld_hp_i,
    output logic             run_o,
    output logic             pend_o,
    output logic             lp_o,
    output logic             clk_o,
    output logic             rise_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic [CNT_W-1:0] php_q, php_d;
    logic             pend_q, pend_d;
    logic             run_q, run_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;

    logic [CNT_W-1:0] hp_m1;
    logic             tog;
    logic             fall;
    logic             lp;

    assign hp_m1 = hp_q - 1'b1;
    assign tog   = run_q && (cnt_q == hp_m1);
    assign fall  = tog && clk_q;
    // Loads are only safe once the clock is (or is about to be) low.
    assign lp    = !run_q || fall;

    always_comb begin
        cnt_d  = cnt_q;
        hp_d   = hp_q;
        php_d  = php_q;
        pend_d = pend_q;
        run_d  = run_q;
        clk_d  = clk_q;
        if (run_q) begin
            if (tog) begin
                cnt_d = '0;
                clk_d = !clk_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (lp && pend_q) begin
            hp_d   = php_q;
            pend_d = 1'b0;
            cnt_d  = '0;
        end
        if (!go_i) begin
            if (run_q && (!clk_q || fall)) begin
                run_d = 1'b0;
                clk_d = 1'b0;
                cnt_d = '0;
            end
        end else if (!run_q) begin
            run_d = 1'b1;
            cnt_d = '0;
        end
        if (ld_i) begin
            pend_d = 1'b1;
            php_d  = ld_hp_i;
        end
        rise_d = clk_d && !clk_q;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            hp_q   <= CNT_W'(HP_RST);
            php_q  <= '0;
            pend_q <= 1'b0;
            run_q  <= 1'b0;
            clk_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hp_q   <= hp_d;
            php_q  <= php_d;
            pend_q <= pend_d;
            run_q  <= run_d;
            clk_q  <= clk_d;
            rise_q <= rise_d;
        end
    end

    assign run_o  = run_q;
    assign pend_o = pend_q;
    assign lp_o   = lp;
    assign clk_o  = clk_q;
    assign rise_o = rise_q;

endmodule

// File: rtl/clk_div_sched.sv
// Write/read FIFO clock scheduler: top FSM, config handshake and
// two divided-clock channels with glitch-free start/stop/reprogram.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int WR_HP_RST = WR_HP_DEF,
    parameter int RD_HP_RST = RD_HP_DEF
) (
    input logic             clk_in,
    input logic             reset_n,
    clk_div_sched_if.slave  bus
);

    state_e state_q, state_d;
    logic   err_q, err_d;

    logic   xfer;
    logic   bad;
    logic   acc;
    logic   go;
    logic   done;

    logic   w_run, w_pend, w_lp;
    logic   r_run, r_pend, r_lp;

    assign xfer = bus.cfg_valid && (state_q != UPDATE);
    assign bad  = (bus.cfg_wr_hp == '0) || (bus.cfg_rd_hp == '0);
    assign acc  = xfer && !bad;
    // A transfer edge holds the run decision; run_en is re-evaluated next cycle.
    assign go   = xfer ? (state_q == RUN) : bus.run_en;
    assign done = (!w_pend || w_lp) && (!r_pend || r_lp);

    always_comb begin
        state_d = state_q;
        err_d   = xfer && bad;
        unique case (state_q)
            IDLE: begin
                if (acc)             state_d = UPDATE;
                else if (bus.run_en) state_d = RUN;
            end
            RUN: begin
                if (acc)              state_d = UPDATE;
                else if (!bus.run_en) state_d = DRAIN;
            end
            DRAIN: begin
                if (acc)                 state_d = UPDATE;
                else if (bus.run_en)     state_d = RUN;
                else if (!w_run && !r_run) state_d = IDLE;
            end
            UPDATE: begin
                if (done) begin
                    if (bus.run_en)        state_d = RUN;
                    else if (w_run || r_run) state_d = DRAIN;
                    else                   state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    clk_div_chan #(
        .CNT_W  (CNT_W),
        .HP_RST (WR_HP_RST)
    ) u_w (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .go_i    (go),
        .ld_i    (acc),
        .ld_hp_i (bus.cfg_wr_hp),
        .run_o   (w_run),
        .pend_o  (w_pend),
        .lp_o    (w_lp),
        .clk_o   (bus.w_clk),
        .rise_o  (bus.w_clk_rise)
    );

    clk_div_chan #(
        .CNT_W  (CNT_W),
        .HP_RST (RD_HP_RST)
    ) u_r (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .go_i    (go),
        .ld_i    (acc),
        .ld_hp_i (bus.cfg_rd_hp),
        .run_o   (r_run),
        .pend_o  (r_pend),
        .lp_o    (r_lp),
        .clk_o   (bus.r_clk),
        .rise_o  (bus.r_clk_rise)
    );

    assign bus.cfg_ready = (state_q != UPDATE);
    assign bus.cfg_err   = err_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched: expected waveform vectors are queued
// ahead of time and popped as the DUT advances.
module tb_clk_div_sched;

    localparam int W = 8;

    typedef struct {
        logic [4:0] v;
        logic [4:0] m;
    } exp_t;

    logic clk_in  = 1'b0;
    logic reset_n = 1'b0;
    int   nvec    = 0;
    int   nmis    = 0;
    exp_t sbq[$];

    always #5 clk_in = ~clk_in;

    clk_div_sched_if #(.CNT_W(W)) bus ();

    clk_div_sched #(
        .CNT_W     (W),
        .WR_HP_RST (3),
        .RD_HP_RST (2)
    ) dut (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] v, input logic [4:0] m);
        exp_t e;
        e.v = v;
        e.m = m;
        sbq.push_back(e);
    endtask

    // Observed vector: {w_clk, r_clk, w_clk_rise, r_clk_rise, busy}
    task automatic sb_cmp(input string tag);
        exp_t       e;
        logic [4:0] o;
        if (sbq.size() == 0) begin
            chk({tag, "_sbq_empty"}, 8'd0, 8'd1);
            return;
        end
        e = sbq.pop_front();
        o = {bus.w_clk, bus.r_clk, bus.w_clk_rise, bus.r_clk_rise, bus.busy};
        nvec++;
        assert ((o & e.m) === (e.v & e.m)) else begin
            nmis++;
            $error("FAIL %s observed=%b expected=%b mask=%b", tag, o, e.v, e.m);
        end
    endtask

    function automatic logic ph(input int k, input int hp);
        return (k >= hp) && (((k - hp) % (2 * hp)) < hp);
    endfunction

    function automatic logic rs(input int k, input int hp);
        return (k >= hp) && (((k - hp) % (2 * hp)) == 0);
    endfunction

    // Both channels stopped; the next edge samples run_en=1.
    task automatic check_fixed(input int hpw, input int hpr, input int n,
                               input string tag);
        for (int k = 0; k < n; k++)
            push({ph(k, hpw), ph(k, hpr), rs(k, hpw), rs(k, hpr), 1'b1},
                 5'b11111);
        for (int k = 0; k < n; k++) begin
            step();
            sb_cmp(tag);
        end
    endtask

    task automatic check_chan(input bit isw, input int hp, input int nper,
                              input string tag);
        int   t;
        logic hi, rz;
        t = 0;
        while (!(isw ? bus.w_clk_rise : bus.r_clk_rise) && t < 200) begin
            step();
            t++;
        end
        chk({tag, "_sync"}, isw ? bus.w_clk_rise : bus.r_clk_rise, 8'd1);
        for (int i = 0; i < 2 * hp * nper; i++) begin
            hi = (i % (2 * hp)) < hp;
            rz = (i % (2 * hp)) == 0;
            if (isw) push({hi, 1'b0, rz, 1'b0, 1'b0}, 5'b10100);
            else     push({1'b0, hi, 1'b0, rz, 1'b0}, 5'b01010);
        end
        for (int i = 0; i < 2 * hp * nper; i++) begin
            sb_cmp(tag);
            step();
        end
    endtask

    task automatic send_cfg(input logic [W-1:0] wr, input logic [W-1:0] rd);
        bus.cfg_valid = 1'b1;
        bus.cfg_wr_hp = wr;
        bus.cfg_rd_hp = rd;
        step();
        bus.cfg_valid = 1'b0;
    endtask

    // Tracks the shortest complete phase of each clock and whether ready returned.
    task automatic watch(input int n, output int minw, output int minr,
                         output bit rdy);
        logic pw, pr;
        int   lw, lr;
        bit   sw, sr;
        pw = bus.w_clk; pr = bus.r_clk;
        lw = 0; lr = 0; sw = 0; sr = 0;
        minw = 999; minr = 999; rdy = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (bus.cfg_ready) rdy = 1;
            if (bus.w_clk != pw) begin
                if (sw && lw < minw) minw = lw;
                sw = 1; lw = 1; pw = bus.w_clk;
            end else lw++;
            if (bus.r_clk != pr) begin
                if (sr && lr < minr) minr = lr;
                sr = 1; lr = 1; pr = bus.r_clk;
            end else lr++;
        end
    endtask

    initial begin
        int minw, minr, t;
        bit rdy;

        bus.run_en    = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_wr_hp = '0;
        bus.cfg_rd_hp = '0;

        #2;
        chk("rst_outs", {bus.w_clk, bus.r_clk, bus.w_clk_rise,
                         bus.r_clk_rise, bus.busy}, 8'd0);
        chk("rst_ready", bus.cfg_ready, 8'd1);
        chk("rst_err", bus.cfg_err, 8'd0);

        // Start: w rises 3 edges after the sample edge, r after 2.
        @(negedge clk_in);
        reset_n = 1'b1;
        bus.run_en = 1'b1;
        check_fixed(3, 2, 24, "t1_start");

        // Zero half-period rejected, periods kept.
        send_cfg(8'd0, 8'd4);
        chk("t3_err", bus.cfg_err, 8'd1);
        chk("t3_ready", bus.cfg_ready, 8'd1);
        chk("t3_busy", bus.busy, 8'd1);
        step();
        chk("t3_err_clr", bus.cfg_err, 8'd0);
        check_chan(1'b1, 3, 2, "t3_w");
        check_chan(1'b0, 2, 2, "t3_r");

        // Reprogram while running.
        send_cfg(8'd5, 8'd1);
        chk("t2_ready_lo", bus.cfg_ready, 8'd0);
        chk("t2_busy", bus.busy, 8'd1);
        watch(40, minw, minr, rdy);
        chk("t2_ready_back", rdy, 8'd1);
        chk("t2_no_runt_w", minw >= 3, 8'd1);
        chk("t2_no_runt_r", minr >= 1, 8'd1);
        check_chan(1'b1, 5, 2, "t2_w");
        check_chan(1'b0, 1, 2, "t2_r");

        send_cfg(8'd3, 8'd2);
        watch(30, minw, minr, rdy);
        chk("rest_ready", rdy, 8'd1);
        check_chan(1'b1, 3, 1, "rest_w");

        // Stop one cycle after a w rise.
        t = 0;
        while (!bus.w_clk_rise && t < 50) begin
            step();
            t++;
        end
        chk("t4_sync", bus.w_clk_rise, 8'd1);
        bus.run_en = 1'b0;
        push(5'b10001, 5'b10101);
        push(5'b10001, 5'b10101);
        push(5'b00001, 5'b11111);
        for (int k = 0; k < 5; k++) push(5'b00000, 5'b11111);
        for (int k = 0; k < 8; k++) begin
            step();
            sb_cmp("t4_drain");
        end

        // Config in IDLE: one busy cycle, then new periods.
        send_cfg(8'd2, 8'd7);
        chk("t5_busy", bus.busy, 8'd1);
        chk("t5_ready_lo", bus.cfg_ready, 8'd0);
        step();
        chk("t5_busy_lo", bus.busy, 8'd0);
        chk("t5_ready_hi", bus.cfg_ready, 8'd1);
        bus.run_en = 1'b1;
        check_fixed(2, 7, 11, "t5_run");

        // Async reset while both clocks are high.
        chk("t6_both_hi", {bus.w_clk, bus.r_clk}, 8'd3);
        reset_n = 1'b0;
        bus.run_en = 1'b0;
        #1;
        chk("t6_async", {bus.w_clk, bus.r_clk, bus.w_clk_rise,
                         bus.r_clk_rise, bus.busy}, 8'd0);
        step();
        step();
        chk("t6_ready", bus.cfg_ready, 8'd1);
        chk("t6_err", bus.cfg_err, 8'd0);
        @(negedge clk_in);
        reset_n = 1'b1;
        bus.run_en = 1'b1;
        check_fixed(3, 2, 14, "t6_restart");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
